// File: rtl/ex_branch_resolve.sv
`default_nettype none
// ============================================================================
// Module   : ex_branch_resolve
// Purpose  : EX-stage branch/jump resolution, mispredict redirect, predictor
//            update and performance counting.
// Revision : 1.0 - initial release
// ============================================================================
module ex_branch_resolve #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_ex_i,
    input  logic             branch_ex_i,
    input  logic             jump_ex_i,
    input  logic             brn_pred_ex_i,
    input  logic             brn_taken_ex_i,
    input  logic [31:0]      curr_pc_ex_i,
    input  logic [31:0]      next_pred_pc_ex_i,
    input  logic [31:0]      next_seq_pc_ex_i,
    input  logic [31:0]      brn_eq_pc_ex_i,
    input  logic [31:0]      jump_tgt_ex_i,
    input  logic             redirect_ready_i,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             kill_ex_o,
    output logic             bp_upd_valid_o,
    output logic [31:0]      bp_upd_pc_o,
    output logic             bp_upd_taken_o,
    output logic [31:0]      bp_upd_tgt_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_REDIRECT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic             w_idle;
    logic             w_resolve;
    logic             w_mispredict;
    logic [31:0]      w_actual_pc;
    logic [31:0]      r_redirect_pc;
    logic             r_upd_valid;
    logic [31:0]      r_upd_pc;
    logic             r_upd_taken;
    logic [31:0]      r_upd_tgt;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    // The fetch-time direction bit is implied by next_pred_pc; only the PC is compared.
    logic w_unused_pred;
    assign w_unused_pred = brn_pred_ex_i;

    assign w_idle       = (r_state == S_IDLE);
    assign w_resolve    = valid_ex_i & (branch_ex_i | jump_ex_i) & w_idle;
    assign w_actual_pc  = jump_ex_i   ? jump_tgt_ex_i :
                          branch_ex_i ? (brn_taken_ex_i ? brn_eq_pc_ex_i : next_seq_pc_ex_i) :
                                        next_seq_pc_ex_i;
    // Non-branch instructions are checked too, catching predictor aliasing.
    assign w_mispredict = valid_ex_i & w_idle & (w_actual_pc != next_pred_pc_ex_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_mispredict)     w_next_state = S_REDIRECT;
            S_REDIRECT: if (redirect_ready_i) w_next_state = S_IDLE;
            default:                          w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        redirect_valid_o = 1'b0;
        flush_o          = 1'b0;
        kill_ex_o        = 1'b0;
        if (r_state == S_REDIRECT) begin
            redirect_valid_o = 1'b1;
            flush_o          = 1'b1;
            kill_ex_o        = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_pc <= 32'h0;
            r_upd_valid   <= 1'b0;
            r_upd_pc      <= 32'h0;
            r_upd_taken   <= 1'b0;
            r_upd_tgt     <= 32'h0;
            r_br_cnt      <= '0;
            r_mis_cnt     <= '0;
        end else begin
            r_upd_valid <= w_resolve;
            if (w_mispredict) begin
                r_redirect_pc <= w_actual_pc;
            end
            if (w_resolve) begin
                r_upd_pc    <= curr_pc_ex_i;
                r_upd_taken <= jump_ex_i | brn_taken_ex_i;
                r_upd_tgt   <= w_actual_pc;
            end
            if (w_resolve && (r_br_cnt != {CNT_W{1'b1}})) begin
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mis_cnt != {CNT_W{1'b1}})) begin
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
            end
        end
    end

    assign redirect_pc_o  = r_redirect_pc;
    assign bp_upd_valid_o = r_upd_valid;
    assign bp_upd_pc_o    = r_upd_pc;
    assign bp_upd_taken_o = r_upd_taken;
    assign bp_upd_tgt_o   = r_upd_tgt;
    assign br_cnt_o       = r_br_cnt;
    assign mispred_cnt_o  = r_mis_cnt;

endmodule
`default_nettype wire
